// File: rtl/mem_arbiter_pkg.sv
// Shared CPU-side definitions for the two-port main-memory arbiter:
// FSM states, requester indices and default bus widths.
package mem_arbiter_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int LINE_W_DEF = 128;

   localparam int REQ_IF = 0;
   localparam int REQ_DC = 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   // One-hot completion vector for a requester index.
   function automatic logic [1:0] onehot2(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-way round-robin grant selection; purely combinational from the
// request vector and the index granted last.
module rr_arbiter2
   import mem_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       valid,
   output logic       grant
);

   assign valid = |req;

   always_comb begin
      // NOTE: every output of a combinational block gets a default before
      // the case, so no path leaves it unassigned and no latch is inferred.
      grant = last_grant;
      case (req)
         2'b01:   grant = 1'(REQ_IF);
         2'b10:   grant = 1'(REQ_DC);
         2'b11:   grant = ~last_grant;
         default: grant = last_grant;
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data-cache line requests onto a single
// main-memory port; one transaction at a time, round-robin on ties.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int LINE_W = LINE_W_DEF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [1:0]        req,
   input  logic [1:0]        we,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [LINE_W-1:0] wdata0,
   input  logic [LINE_W-1:0] wdata1,
   output logic [1:0]        ready,
   output logic [LINE_W-1:0] rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic              mem_ready,
   input  logic [LINE_W-1:0] mem_rdata,
   output logic              busy
);

   localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(4'hF);

   state_t            state;
   state_t            state_nxt;
   logic              grant_valid;
   logic              grant_idx;
   logic              last_grant;
   logic              gnt_q;
   logic              load;
   logic              capture;
   logic [ADDR_W-1:0] sel_addr;
   logic [LINE_W-1:0] sel_wdata;

   rr_arbiter2 u_rr (
      .req        (req),
      .last_grant (last_grant),
      .valid      (grant_valid),
      .grant      (grant_idx)
   );

   assign sel_addr  = grant_idx ? addr1  : addr0;
   assign sel_wdata = grant_idx ? wdata1 : wdata0;

   // State register.
   always_ff @(posedge clock or negedge reset) begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples pre-edge values regardless of block ordering.
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      capture   = 1'b0;
      case (state)
         IDLE: begin
            if (grant_valid) begin
               load      = 1'b1;
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (mem_ready) begin
               capture   = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs decode straight from the state flops, so reset clears them at once.
   always_comb begin
      mem_req = (state == WAIT);
      busy    = (state != IDLE);
      ready   = (state == DONE) ? onehot2(gnt_q) : 2'b00;
   end

   // Request payload is frozen at grant time and held through WAIT.
   always_ff @(posedge clock or negedge reset) begin
      // NOTE: the line-wide data registers are reset too, because the
      // memory port and rdata must read as zero straight after reset.
      if (!reset) begin
         last_grant <= 1'b1;
         gnt_q      <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         rdata      <= '0;
      end else begin
         if (load) begin
            last_grant <= grant_idx;
            gnt_q      <= grant_idx;
            mem_we     <= we[grant_idx];
            mem_addr   <= sel_addr & LINE_MASK;
            mem_wdata  <= sel_wdata;
         end
         if (capture && !mem_we) begin
            rdata <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter; the bench acts as main memory
// and predicts grants, memory contents and rdata from a transaction-level model.
module tb_mem_arbiter;

   localparam int AW = 32;
   localparam int LW = 128;
   typedef logic [LW-1:0] line_t;

   logic           clock = 1'b0;
   logic           reset;
   logic [1:0]     req;
   logic [1:0]     we;
   logic [AW-1:0]  addr0, addr1;
   line_t          wdata0, wdata1;
   logic [1:0]     ready;
   line_t          rdata;
   logic           mem_req, mem_we;
   logic [AW-1:0]  mem_addr;
   line_t          mem_wdata;
   logic           mem_ready;
   line_t          mem_rdata;
   logic           busy;

   int    checks = 0;
   int    errors = 0;
   line_t mem_array [16];
   int    m_last;
   line_t m_rdata;
   logic [1:0] obs_ready;

   mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
      .clock     (clock),
      .reset     (reset),
      .req       (req),
      .we        (we),
      .addr0     (addr0),
      .addr1     (addr1),
      .wdata0    (wdata0),
      .wdata1    (wdata1),
      .ready     (ready),
      .rdata     (rdata),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ready (mem_ready),
      .mem_rdata (mem_rdata),
      .busy      (busy)
   );

   always #5 clock = ~clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got running want finished");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input line_t obs, input line_t exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      @(negedge clock);
   endtask

   function automatic line_t rand_line();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic new_payload(input int r);
      logic [AW-1:0] a;
      a = (AW'($urandom_range(0, 15)) << 4) | AW'($urandom_range(0, 15));
      we[r] = 1'($urandom_range(0, 1));
      if (r == 0) begin addr0 = a; wdata0 = rand_line(); end
      else        begin addr1 = a; wdata1 = rand_line(); end
      req[r] = 1'b1;
   endtask

   // Starts at a negedge in IDLE with req != 0; returns at the negedge of the
   // IDLE cycle after the ready pulse.
   task automatic do_txn(input int lat, input bit stuck, input bit reissue, output int g);
      logic          w;
      logic [AW-1:0] a;
      line_t         wd;
      line_t         exp_rd;
      int            idx;
      g  = (req == 2'b11) ? 1 - m_last : (req[1] ? 1 : 0);
      w  = we[g];
      a  = (g == 1) ? addr1 : addr0;
      a[3:0] = 4'h0;
      wd = (g == 1) ? wdata1 : wdata0;
      idx = int'(a[7:4]);
      exp_rd = m_rdata;
      step();
      check("busy_after_grant", line_t'(busy), line_t'(1'b1));
      check("mem_we", line_t'(mem_we), line_t'(w));
      check("mem_addr", line_t'(mem_addr), line_t'(a));
      check("mem_wdata", mem_wdata, wd);
      for (int c = 1; c <= lat; c++) begin
         check("mem_req_held", line_t'(mem_req), line_t'(1'b1));
         check("mem_addr_held", line_t'(mem_addr), line_t'(a));
         check("ready_in_wait", line_t'(ready), '0);
         if (c == lat) begin
            mem_ready = 1'b1;
            if (w) begin
               mem_array[idx] = mem_wdata;
               mem_rdata      = rand_line();
            end else begin
               mem_rdata = mem_array[idx];
               exp_rd    = mem_array[idx];
            end
         end
         step();
      end
      if (!stuck) mem_ready = 1'b0;
      obs_ready = ready;
      check("ready_pulse", line_t'(ready), line_t'((g == 1) ? 2'b10 : 2'b01));
      check("rdata", rdata, exp_rd);
      check("mem_req_done", line_t'(mem_req), '0);
      check("busy_done", line_t'(busy), line_t'(1'b1));
      m_last  = g;
      m_rdata = exp_rd;
      if (reissue) new_payload(g);
      else         req[g] = 1'b0;
      step();
      check("ready_after", line_t'(ready), '0);
      check("busy_idle", line_t'(busy), '0);
      mem_ready = 1'b0;
   endtask

   initial begin
      int g;
      int cnt0, cnt1;
      line_t l_read, l_write;
      reset = 1'b0; req = '0; we = '0; addr0 = '0; addr1 = '0;
      wdata0 = '0; wdata1 = '0; mem_ready = 1'b0; mem_rdata = '0;
      foreach (mem_array[i]) mem_array[i] = rand_line();
      m_last = 1; m_rdata = '0;

      // Reset state.
      step(); step();
      check("rst_ready", line_t'(ready), '0);
      check("rst_busy", line_t'(busy), '0);
      check("rst_mem_req", line_t'(mem_req), '0);
      check("rst_mem_we", line_t'(mem_we), '0);
      check("rst_mem_addr", line_t'(mem_addr), '0);
      check("rst_mem_wdata", mem_wdata, '0);
      check("rst_rdata", rdata, '0);
      reset = 1'b1;
      step(); step();
      check("idle_no_req", line_t'(busy), '0);

      // Tie straight after reset: requester 0 first, then 1.
      new_payload(0); new_payload(1);
      do_txn(2, 0, 0, g);
      check("tie_first", line_t'(obs_ready), line_t'(2'b01));
      do_txn(2, 0, 0, g);
      check("tie_second", line_t'(obs_ready), line_t'(2'b10));

      // Single read: line 1 with latency 3.
      l_read = {32'd4, 32'd3, 32'd2, 32'd1};
      mem_array[1] = l_read;
      req = 2'b01; we = 2'b00; addr0 = 32'h14;
      do_txn(3, 0, 0, g);
      check("read_rdata", rdata, l_read);

      // Single write from the data side.
      l_write = {32'd0, 32'd15, 32'd10, 32'd5};
      req = 2'b10; we = 2'b10; addr1 = 32'h0; wdata1 = l_write;
      do_txn(2, 0, 0, g);
      check("write_mem", mem_array[0], l_write);
      check("write_rdata_kept", rdata, l_read);

      // mem_ready stuck high through DONE and the following cycle.
      req = 2'b01; we = 2'b00; addr0 = 32'h2C;
      do_txn(1, 1, 0, g);
      step();
      check("stuck_no_repulse", line_t'(ready), '0);

      // Continuous contention, 8 transactions.
      cnt0 = 0; cnt1 = 0;
      new_payload(0); new_payload(1);
      for (int i = 0; i < 8; i++) begin
         do_txn(int'($urandom_range(1, 3)), 0, 1, g);
         cnt0 += int'(obs_ready[0]);
         cnt1 += int'(obs_ready[1]);
      end
      req = 2'b00;
      check("contend_cnt0", line_t'(cnt0), line_t'(4));
      check("contend_cnt1", line_t'(cnt1), line_t'(4));
      step();

      // Randomized traffic against the model.
      for (int i = 0; i < 40; i++) begin
         for (int r = 0; r < 2; r++)
            if (!req[r] && $urandom_range(0, 1) == 1) new_payload(r);
         if (req == 2'b00) new_payload(int'($urandom_range(0, 1)));
         do_txn(int'($urandom_range(1, 4)), 0, 0, g);
      end
      req = 2'b00;
      step();

      // Reset in the middle of WAIT.
      req = 2'b01; we = 2'b00; addr0 = 32'h50;
      step(); step();
      reset = 1'b0;
      #1;
      check("midrst_mem_req", line_t'(mem_req), '0);
      check("midrst_busy", line_t'(busy), '0);
      check("midrst_ready", line_t'(ready), '0);
      check("midrst_mem_addr", line_t'(mem_addr), '0);
      check("midrst_rdata", rdata, '0);
      req = 2'b00;
      m_last = 1; m_rdata = '0;
      step();
      reset = 1'b1;
      step();
      mem_ready = 1'b1; mem_rdata = rand_line();
      step();
      mem_ready = 1'b0;
      check("stray_ready", line_t'(ready), '0);
      check("stray_busy", line_t'(busy), '0);
      step();
      check("stray_ready2", line_t'(ready), '0);

      // last_grant restored by reset: requester 0 wins the tie again.
      new_payload(0); new_payload(1);
      do_txn(1, 0, 0, g);
      check("post_rst_tie", line_t'(obs_ready), line_t'(2'b01));
      do_txn(1, 0, 0, g);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
